// File: rtl/rtc_pkg.sv
// Shared types, owner IDs, timing defaults and output decode for the RTC bus sequencer.
package rtc_pkg;

  localparam int unsigned T_SU_DEF = 2;
  localparam int unsigned T_PW_DEF = 4;
  localparam int unsigned T_H_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_SU = 3'd1,
    ST_ADDR_PW = 3'd2,
    ST_ADDR_H  = 3'd3,
    ST_DATA_SU = 3'd4,
    ST_DATA_PW = 3'd5,
    ST_DATA_H  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OWN_IN = 2'd0,
    OWN_WR = 2'd1,
    OWN_RD = 2'd2
  } owner_t;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad_n;
    logic fase_dir;
    logic drive_en;
    logic sel_in;
    logic sel_wr;
    logic sel_rd;
    logic done_in;
    logic done_wr;
    logic done_rd;
    logic ocupado;
  } bus_out_t;

  localparam bus_out_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_n: 1'b1, default: 1'b0};

  // Successor in the fixed cycle sequence; DONE wraps to IDLE.
  function automatic state_t next_state(state_t st);
    return (st == ST_DONE) ? ST_IDLE : state_t'(3'(st) + 3'd1);
  endfunction

  // Bus outputs as a pure function of state and owner.
  function automatic bus_out_t bus_decode(state_t st, owner_t own);
    bus_out_t o;
    logic addr;
    logic data;
    logic busy;
    logic is_rd;
    o     = BUS_IDLE;
    addr  = (st == ST_ADDR_SU) || (st == ST_ADDR_PW) || (st == ST_ADDR_H);
    data  = (st == ST_DATA_SU) || (st == ST_DATA_PW) || (st == ST_DATA_H);
    busy  = addr || data;
    is_rd = (own == OWN_RD);
    o.cs_n     = !busy;
    o.ad_n     = !addr;
    o.fase_dir = addr;
    o.sel_in   = busy && (own == OWN_IN);
    o.sel_wr   = busy && (own == OWN_WR);
    o.sel_rd   = busy && is_rd;
    o.wr_n     = !((st == ST_ADDR_PW) || ((st == ST_DATA_PW) && !is_rd));
    o.rd_n     = !((st == ST_DATA_PW) && is_rd);
    o.drive_en = addr || (data && !is_rd);
    o.done_in  = (st == ST_DONE) && (own == OWN_IN);
    o.done_wr  = (st == ST_DONE) && (own == OWN_WR);
    o.done_rd  = (st == ST_DONE) && is_rd;
    o.ocupado  = (st != ST_IDLE);
    return o;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Engine handshake and RTC bus strobe/select bundle.
interface rtc_bus_sequencer_if;
  logic       req_in, req_wr, req_rd;
  logic       done_in, done_wr, done_rd;
  logic       Selin, Selrd, Selwr;
  logic       fase_dir;
  logic       cs_n, rd_n, wr_n, ad_n;
  logic       drive_en;
  logic [7:0] rtc_in;
  logic [7:0] dato_rd;
  logic       ocupado;

  modport slave (
    input  req_in, req_wr, req_rd, rtc_in,
    output done_in, done_wr, done_rd, Selin, Selrd, Selwr, fase_dir,
           cs_n, rd_n, wr_n, ad_n, drive_en, dato_rd, ocupado
  );

  modport master (
    output req_in, req_wr, req_rd, rtc_in,
    input  done_in, done_wr, done_rd, Selin, Selrd, Selwr, fase_dir,
           cs_n, rd_n, wr_n, ad_n, drive_en, dato_rd, ocupado
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; fin is high during the last cycle of the loaded duration.
module rtc_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         fin
);

  logic [W-1:0] cnt;

  // Count down to zero after each load; fin flags the final cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      fin <= 1'b0;
    end else if (load) begin
      cnt <= load_val - W'(1);
      fin <= (load_val == W'(1));
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
      fin <= (cnt == W'(1));
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Arbitrates the init/write/read engines and sequences two-phase RTC bus cycles.
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned T_SU = T_SU_DEF,
  parameter int unsigned T_PW = T_PW_DEF,
  parameter int unsigned T_H  = T_H_DEF
) (
  input  logic clk,
  input  logic reset,
  rtc_bus_sequencer_if.slave bus
);

  localparam int unsigned T_MAX0 = (T_SU > T_PW) ? T_SU : T_PW;
  localparam int unsigned T_MAX  = (T_MAX0 > T_H) ? T_MAX0 : T_H;
  localparam int unsigned CW     = $clog2(T_MAX) + 1;

  state_t         state;
  owner_t         owner;
  bus_out_t       outs;
  logic [7:0]     dato_rd;
  logic           fin;
  state_t         tgt_c;
  owner_t         win_c;
  logic           any_req_c;
  logic           load_c;
  logic [CW-1:0]  load_val_c;

  // Priority pick, timer reload on every state entry, duration of the entered state.
  always_comb begin
    tgt_c     = next_state(state);
    any_req_c = bus.req_in || bus.req_wr || bus.req_rd;
    win_c     = OWN_RD;
    if (bus.req_in)      win_c = OWN_IN;
    else if (bus.req_wr) win_c = OWN_WR;
    load_c = 1'b0;
    if (state == ST_IDLE)      load_c = any_req_c;
    else if (state != ST_DONE) load_c = fin;
    case (tgt_c)
      ST_ADDR_SU, ST_DATA_SU: load_val_c = CW'(T_SU);
      ST_ADDR_PW, ST_DATA_PW: load_val_c = CW'(T_PW);
      default:                load_val_c = CW'(T_H);
    endcase
  end

  rtc_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .load_val (load_val_c),
    .fin      (fin)
  );

  // State, owner, registered bus outputs and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= OWN_IN;
      outs    <= BUS_IDLE;
      dato_rd <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req_c) begin
            state <= ST_ADDR_SU;
            owner <= win_c;
            outs  <= bus_decode(ST_ADDR_SU, win_c);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          outs  <= BUS_IDLE;
        end
        default: begin
          if (fin) begin
            state <= tgt_c;
            outs  <= bus_decode(tgt_c, owner);
          end
        end
      endcase
      if ((state == ST_DATA_PW) && fin && (owner == OWN_RD))
        dato_rd <= bus.rtc_in;
    end
  end

  assign bus.cs_n     = outs.cs_n;
  assign bus.rd_n     = outs.rd_n;
  assign bus.wr_n     = outs.wr_n;
  assign bus.ad_n     = outs.ad_n;
  assign bus.fase_dir = outs.fase_dir;
  assign bus.drive_en = outs.drive_en;
  assign bus.Selin    = outs.sel_in;
  assign bus.Selwr    = outs.sel_wr;
  assign bus.Selrd    = outs.sel_rd;
  assign bus.done_in  = outs.done_in;
  assign bus.done_wr  = outs.done_wr;
  assign bus.done_rd  = outs.done_rd;
  assign bus.ocupado  = outs.ocupado;
  assign bus.dato_rd  = dato_rd;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench: default-timing DUT (index 0) and minimum-timing DUT (index 1).
module tb_rtc_bus_sequencer;

  localparam int O_IN = 0;
  localparam int O_WR = 1;
  localparam int O_RD = 2;

  typedef struct {
    int         own;
    int         len;
    int         wr_lo;
    int         rd_lo;
    int         drv_lo;
    int         ad_lo;
    logic [7:0] dato;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [7:0] rd_byte0, rd_byte1;
  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];

  rtc_bus_sequencer_if b0();
  rtc_bus_sequencer_if b1();

  rtc_bus_sequencer #(.T_SU(2), .T_PW(4), .T_H(2)) dut0 (.clk(clk), .reset(rst0), .bus(b0.slave));
  rtc_bus_sequencer #(.T_SU(1), .T_PW(1), .T_H(1)) dut1 (.clk(clk), .reset(rst1), .bus(b1.slave));

  always #5 clk = ~clk;

  // RTC model: presents the byte only while rd_n is low.
  assign b0.rtc_in = b0.rd_n ? 8'hFF : rd_byte0;
  assign b1.rtc_in = b1.rd_n ? 8'hFF : rd_byte1;

  logic [1:0] cs_n_a, rd_n_a, wr_n_a, ad_n_a, drv_a, fase_a, ocu_a;
  logic [2:0] sel_a [2];
  logic [2:0] done_a[2];
  logic [7:0] dato_a[2];

  assign cs_n_a = {b1.cs_n, b0.cs_n};
  assign rd_n_a = {b1.rd_n, b0.rd_n};
  assign wr_n_a = {b1.wr_n, b0.wr_n};
  assign ad_n_a = {b1.ad_n, b0.ad_n};
  assign drv_a  = {b1.drive_en, b0.drive_en};
  assign fase_a = {b1.fase_dir, b0.fase_dir};
  assign ocu_a  = {b1.ocupado, b0.ocupado};
  assign sel_a[0]  = {b0.Selrd, b0.Selwr, b0.Selin};
  assign sel_a[1]  = {b1.Selrd, b1.Selwr, b1.Selin};
  assign done_a[0] = {b0.done_rd, b0.done_wr, b0.done_in};
  assign done_a[1] = {b1.done_rd, b1.done_wr, b1.done_in};
  assign dato_a[0] = b0.dato_rd;
  assign dato_a[1] = b1.dato_rd;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int i, input int own, input int len, input int wr_lo, input int rd_lo,
                      input int drv_lo, input int ad_lo, input logic [7:0] dato, input int gap);
    exp_t e;
    e.own = own; e.len = len; e.wr_lo = wr_lo; e.rd_lo = rd_lo;
    e.drv_lo = drv_lo; e.ad_lo = ad_lo; e.dato = dato; e.gap = gap;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int front_gap(input int i);
    if (i == 0) return (q0.size() > 0) ? q0[0].gap : -1;
    return (q1.size() > 0) ? q1[0].gap : -1;
  endfunction

  function automatic exp_t pop_exp(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int out_vec(input int i);
    return int'({cs_n_a[i], rd_n_a[i], wr_n_a[i], ad_n_a[i], sel_a[i], done_a[i],
                 drv_a[i], fase_a[i], ocu_a[i]});
  endfunction

  localparam int RESET_VEC = 32'b1_1_1_1_000_000_0_0_0;

  // Monitor: measures each transaction and checks it against the queued expectation at done.
  int   m_len[2], m_wr[2], m_rd[2], m_drv[2], m_ad[2], m_gap[2];
  bit   m_act[2], m_had_done[2], m_multi[2];
  logic [2:0] m_sel[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_had_done[i] = 0; m_gap[i] = 0;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    int   fg;
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i] && !cs_n_a[i]) begin
        fg = front_gap(i);
        if (m_had_done[i] && fg >= 0) check($sformatf("gap%0d", i), m_gap[i], fg);
        m_act[i] = 1; m_len[i] = 0; m_wr[i] = 0; m_rd[i] = 0; m_drv[i] = 0; m_ad[i] = 0;
        m_sel[i] = 3'b000; m_multi[i] = 0; m_had_done[i] = 0;
      end
      if (m_act[i]) begin
        m_len[i]++;
        if (!wr_n_a[i]) m_wr[i]++;
        if (!rd_n_a[i]) m_rd[i]++;
        if (!ad_n_a[i]) m_ad[i]++;
        if (!cs_n_a[i] && !drv_a[i]) m_drv[i]++;
        m_sel[i] = m_sel[i] | sel_a[i];
        if ($countones(sel_a[i]) > 1) m_multi[i] = 1;
      end
      if (done_a[i] != 3'b000) begin
        if (!m_act[i] || qsize(i) == 0) begin
          check($sformatf("done_unexpected%0d", i), int'(done_a[i]), 0);
        end else begin
          e = pop_exp(i);
          check($sformatf("done_owner%0d", i), int'(done_a[i]), 1 << e.own);
          check($sformatf("length%0d", i), m_len[i], e.len);
          check($sformatf("wr_low%0d", i), m_wr[i], e.wr_lo);
          check($sformatf("rd_low%0d", i), m_rd[i], e.rd_lo);
          check($sformatf("drive_off%0d", i), m_drv[i], e.drv_lo);
          check($sformatf("ad_low%0d", i), m_ad[i], e.ad_lo);
          check($sformatf("sel%0d", i), int'(m_sel[i]), 1 << e.own);
          check($sformatf("sel_onehot%0d", i), int'(m_multi[i]), 0);
          check($sformatf("dato_rd%0d", i), int'(dato_a[i]), int'(e.dato));
        end
        m_act[i] = 0; m_gap[i] = 0; m_had_done[i] = 1;
      end else if (m_act[i] && !ocu_a[i]) begin
        m_act[i] = 0; m_had_done[i] = 0;
      end else if (!m_act[i]) begin
        m_gap[i]++;
      end
    end
  end

  task automatic wait_done(input int i, input int which);
    bit got;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done_a[i][which]) got = 1;
    end
    if (!got) check($sformatf("done_timeout%0d_%0d", i, which), 0, 1);
  endtask

  initial begin
    bit seen;
    b0.req_in = 0; b0.req_wr = 0; b0.req_rd = 0;
    b1.req_in = 0; b1.req_wr = 0; b1.req_rd = 0;
    rd_byte0 = 8'h00; rd_byte1 = 8'h00;
    rst0 = 1; rst1 = 1;
    repeat (3) @(negedge clk);
    check("reset_outs0", out_vec(0), RESET_VEC);
    check("reset_outs1", out_vec(1), RESET_VEC);
    check("reset_dato0", int'(dato_a[0]), 0);
    rst0 = 0; rst1 = 0;
    @(negedge clk);

    // Single write
    push(0, O_WR, 17, 8, 0, 0, 8, 8'h00, -1);
    b0.req_wr = 1;
    @(negedge clk);
    check("wr_latency", int'({b0.cs_n, b0.Selwr}), 1);
    wait_done(0, O_WR);
    b0.req_wr = 0;

    // Read returning A5
    rd_byte0 = 8'hA5;
    push(0, O_RD, 17, 4, 4, 8, 8, 8'hA5, 1);
    b0.req_rd = 1;
    wait_done(0, O_RD);
    b0.req_rd = 0;
    repeat (3) @(negedge clk);

    // Simultaneous requests: init, write, read
    rd_byte0 = 8'h3C;
    push(0, O_IN, 17, 8, 0, 0, 8, 8'hA5, -1);
    push(0, O_WR, 17, 8, 0, 0, 8, 8'hA5, 1);
    push(0, O_RD, 17, 4, 4, 8, 8, 8'h3C, 1);
    b0.req_in = 1; b0.req_wr = 1; b0.req_rd = 1;
    wait_done(0, O_IN);
    b0.req_in = 0;
    wait_done(0, O_WR);
    b0.req_wr = 0;
    wait_done(0, O_RD);
    b0.req_rd = 0;
    repeat (2) @(negedge clk);

    // Reset in DATA_PW of a write, then restart with req held
    b0.req_wr = 1;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (!b0.wr_n && b0.ad_n) seen = 1;
    end
    check("reach_data_pw", int'(seen), 1);
    rst0 = 1;
    @(negedge clk);
    check("abort_outs", out_vec(0), RESET_VEC);
    check("abort_dato", int'(dato_a[0]), 0);
    rst0 = 0;
    push(0, O_WR, 17, 8, 0, 0, 8, 8'h00, -1);
    @(negedge clk);
    check("restart", int'({b0.cs_n, b0.Selwr}), 1);
    wait_done(0, O_WR);
    b0.req_wr = 0;
    repeat (2) @(negedge clk);

    // Read request dropped during ADDR_H
    rd_byte0 = 8'hC3;
    push(0, O_RD, 17, 4, 4, 8, 8, 8'hC3, -1);
    b0.req_rd = 1;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!b0.wr_n && !b0.ad_n) seen = 1;
      if (seen && b0.wr_n && !b0.ad_n) break;
    end
    b0.req_rd = 0;
    wait_done(0, O_RD);
    repeat (2) @(negedge clk);

    // Minimum timing DUT: write then back-to-back read
    push(1, O_WR, 7, 2, 0, 0, 3, 8'h00, -1);
    b1.req_wr = 1;
    @(negedge clk);
    check("min_wr_latency", int'({b1.cs_n, b1.Selwr}), 1);
    wait_done(1, O_WR);
    b1.req_wr = 0;
    rd_byte1 = 8'h77;
    push(1, O_RD, 7, 1, 1, 3, 3, 8'h77, 1);
    b1.req_rd = 1;
    wait_done(1, O_RD);
    b1.req_rd = 0;
    repeat (3) @(negedge clk);

    check("queue0_empty", q0.size(), 0);
    check("queue1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
